// File: rtl/probe_phase_sweeper_if.sv
// probe_phase_sweeper_if: start/abort/result bus plus MMCM phase-shift port of the sweeper.
interface probe_phase_sweeper_if #(
    parameter int STEP_W  = 10,
    parameter int COUNT_W = 14
);
    logic               start;
    logic               abort;
    logic               busy;
    logic               done;
    logic               timeout_err;
    logic               psen;
    logic               psincdec;
    logic               psdone;
    logic               trigger_out;
    logic               probe_sync;
    logic               res_valid;
    logic [STEP_W-1:0]  res_step;
    logic [COUNT_W-1:0] res_count;
    logic               edge_found;
    logic [STEP_W-1:0]  edge_step;
    modport master (
        output start, abort, psdone, probe_sync,
        input  busy, done, timeout_err, psen, psincdec, trigger_out,
               res_valid, res_step, res_count, edge_found, edge_step
    );
    modport slave (
        input  start, abort, psdone, probe_sync,
        output busy, done, timeout_err, psen, psincdec, trigger_out,
               res_valid, res_step, res_count, edge_found, edge_step
    );
endinterface

// File: rtl/probe_phase_sweeper.sv
// probe_phase_sweeper: steps the MMCM phase, counts probe hits per step, finds the
// first low-to-high crossing of the half-count threshold and unwinds to the start phase.
module probe_phase_sweeper #(
    parameter int NUM_STEPS  = 56,
    parameter int STEP_W     = 10,
    parameter int COUNT_W    = 14,
    parameter int AVER_TIME  = 10000,
    parameter int SETTLE_CYC = 16,
    parameter int PS_TIMEOUT = 1023
) (
    input logic                  shifting_clk,
    input logic                  shifting_rst,
    probe_phase_sweeper_if.slave sw
);
    localparam int CNT_MAX = SETTLE_CYC > PS_TIMEOUT ? SETTLE_CYC : PS_TIMEOUT;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [COUNT_W-1:0] HALF = COUNT_W'(AVER_TIME >> 1);
    localparam logic [COUNT_W-1:0] LAST_TRIG = COUNT_W'(AVER_TIME - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] PS_END = CNT_W'(PS_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, SETTLE, MEAS, RECORD, SHIFT, WAIT_PS, UNWIND, DEC, DEC_WAIT, FINISH, ERR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         phase_q, phase_d;
    logic [COUNT_W-1:0] trig_q, trig_d, hits_q, hits_d, prev_q, prev_d;
    logic [COUNT_W-1:0] res_count_q, res_count_d;
    logic [STEP_W-1:0]  step_q, step_d, res_step_q, res_step_d, edge_step_q, edge_step_d;
    logic               abort_q, abort_d, busy_q, busy_d, done_q, done_d;
    logic               timeout_err_q, timeout_err_d, psen_q, psen_d, psincdec_q, psincdec_d;
    logic               trigger_q, trigger_d, res_valid_q, res_valid_d, edge_found_q, edge_found_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        phase_d       = phase_q;
        trig_d        = trig_q;
        hits_d        = hits_q;
        prev_d        = prev_q;
        step_d        = step_q;
        res_valid_d   = 1'b0;
        res_step_d    = res_step_q;
        res_count_d   = res_count_q;
        edge_found_d  = edge_found_q;
        edge_step_d   = edge_step_q;
        timeout_err_d = timeout_err_q;
        // an abort while a shift is in flight must wait for psdone before unwinding
        abort_d       = abort_q || (sw.abort && (state_q == SHIFT || state_q == WAIT_PS));
        unique case (state_q)
            IDLE: if (sw.start) begin
                state_d       = SETTLE;
                step_d        = '0;
                cnt_d         = '0;
                abort_d       = 1'b0;
                timeout_err_d = 1'b0;
                edge_found_d  = 1'b0;
                edge_step_d   = '0;
            end
            SETTLE: if (sw.abort) begin
                state_d = UNWIND;
                hits_d  = '0;
            end else if (cnt_q == SETTLE_END) begin
                state_d = MEAS;
                phase_d = '0;
                trig_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            MEAS: if (sw.abort) begin
                state_d = UNWIND;
                hits_d  = '0;
                phase_d = '0;
            end else if (phase_q == 3'd3) begin
                hits_d  = &hits_q ? hits_q : hits_q + COUNT_W'(sw.probe_sync);
                phase_d = 3'd4;
            end else if (phase_q == 3'd4) begin
                phase_d = '0;
                trig_d  = trig_q + 1'b1;
                if (trig_q == LAST_TRIG) begin
                    state_d     = RECORD;
                    res_valid_d = 1'b1;
                    res_step_d  = step_q;
                    res_count_d = hits_q;
                    prev_d      = hits_q;
                    hits_d      = '0;
                    if (step_q != '0 && hits_q >= HALF && prev_q < HALF && !edge_found_q) begin
                        edge_found_d = 1'b1;
                        edge_step_d  = step_q;
                    end
                end
            end else begin
                phase_d = phase_q + 3'd1;
            end
            RECORD: state_d = (sw.abort || abort_q || step_q == LAST_STEP) ? UNWIND : SHIFT;
            SHIFT, DEC: begin
                state_d = state_q == SHIFT ? WAIT_PS : DEC_WAIT;
                cnt_d   = '0;
            end
            WAIT_PS, DEC_WAIT: if (sw.psdone) begin
                step_d  = state_q == WAIT_PS ? step_q + 1'b1 : step_q - 1'b1;
                state_d = (state_q == WAIT_PS && !abort_d) ? SETTLE : UNWIND;
                cnt_d   = '0;
            end else if (cnt_q == PS_END) begin
                state_d       = ERR;
                timeout_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            UNWIND: state_d = step_q == '0 ? FINISH : DEC;
            default: state_d = IDLE;
        endcase
        busy_d     = !(state_d == IDLE || state_d == FINISH || state_d == ERR);
        done_d     = state_d == FINISH || state_d == ERR;
        psen_d     = state_d == SHIFT || state_d == DEC;
        psincdec_d = state_d == SHIFT;
        trigger_d  = state_d == MEAS && phase_d == 3'd0;
    end

    always_ff @(posedge shifting_clk or posedge shifting_rst) begin
        if (shifting_rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            phase_q       <= '0;
            trig_q        <= '0;
            hits_q        <= '0;
            prev_q        <= '0;
            step_q        <= '0;
            abort_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            psen_q        <= 1'b0;
            psincdec_q    <= 1'b0;
            trigger_q     <= 1'b0;
            res_valid_q   <= 1'b0;
            res_step_q    <= '0;
            res_count_q   <= '0;
            edge_found_q  <= 1'b0;
            edge_step_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            phase_q       <= phase_d;
            trig_q        <= trig_d;
            hits_q        <= hits_d;
            prev_q        <= prev_d;
            step_q        <= step_d;
            abort_q       <= abort_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
            psen_q        <= psen_d;
            psincdec_q    <= psincdec_d;
            trigger_q     <= trigger_d;
            res_valid_q   <= res_valid_d;
            res_step_q    <= res_step_d;
            res_count_q   <= res_count_d;
            edge_found_q  <= edge_found_d;
            edge_step_q   <= edge_step_d;
        end
    end

    assign sw.busy        = busy_q;
    assign sw.done        = done_q;
    assign sw.timeout_err = timeout_err_q;
    assign sw.psen        = psen_q;
    assign sw.psincdec    = psincdec_q;
    assign sw.trigger_out = trigger_q;
    assign sw.res_valid   = res_valid_q;
    assign sw.res_step    = res_step_q;
    assign sw.res_count   = res_count_q;
    assign sw.edge_found  = edge_found_q;
    assign sw.edge_step   = edge_step_q;
endmodule

// File: tb/tb_probe_phase_sweeper.sv
// tb_probe_phase_sweeper: drives sweeps against an MMCM/probe model and checks each scenario.
module tb_probe_phase_sweeper;
    localparam int STEPS = 4, AVER = 8, HALF = AVER >> 1, MAXC = 63;

    logic clk, rst;
    int checks = 0, errors = 0;

    probe_phase_sweeper_if #(.STEP_W(3), .COUNT_W(6)) u ();
    probe_phase_sweeper_if #(.STEP_W(2), .COUNT_W(3)) u2 ();

    probe_phase_sweeper #(.NUM_STEPS(STEPS), .STEP_W(3), .COUNT_W(6), .AVER_TIME(AVER),
                          .SETTLE_CYC(2), .PS_TIMEOUT(20))
        dut (.shifting_clk(clk), .shifting_rst(rst), .sw(u));

    probe_phase_sweeper #(.NUM_STEPS(2), .STEP_W(2), .COUNT_W(3), .AVER_TIME(7),
                          .SETTLE_CYC(1), .PS_TIMEOUT(8))
        dut_small (.shifting_clk(clk), .shifting_rst(rst), .sw(u2));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Environment model: MMCM phase position, probe generator and per-step hit scoreboard.
    typedef struct { int step; int cnt; int exp; int trigs; } rec_t;
    rec_t recs[$];
    int cyc = 0, pos = 0, incs = 0, decs = 0, done_n = 0, done_cyc = 0, first_psen = -1;
    int overlap = 0, ps_delay = 3, ps_cd = 0, mode = 3, m_hit = 0, m_trig = 0;
    int prob[8];
    bit ps_dir;
    logic [3:0] th = '0;

    initial begin
        bit p;
        rec_t r;
        u.probe_sync = 0;
        u.psdone = 0;
        forever begin
            @(negedge clk);
            cyc++;
            case (mode)
                0: p = $urandom_range(99) < prob[pos & 7];
                1: p = th[2];
                2: p = th[3];
                default: p = pos >= 2;
            endcase
            if (th[2]) begin m_trig++; m_hit += int'(p); end
            th = {th[2:0], u.trigger_out};
            u.probe_sync = p;
            u.psdone = 0;
            if (ps_cd > 0) begin
                ps_cd--;
                if (ps_cd == 0) begin u.psdone = 1; pos += ps_dir ? 1 : -1; end
            end
            if (u.psen === 1'b1) begin
                if (ps_cd > 0) overlap++;
                if (u.psincdec) incs++; else decs++;
                if (first_psen < 0) first_psen = cyc;
                ps_dir = u.psincdec;
                ps_cd = ps_delay;
            end
            if (u.res_valid === 1'b1) begin
                r.step = int'(u.res_step);
                r.cnt = int'(u.res_count);
                r.exp = m_hit > MAXC ? MAXC : m_hit;
                r.trigs = m_trig;
                recs.push_back(r);
                m_hit = 0;
                m_trig = 0;
            end
            if (u.done === 1'b1) begin done_n++; done_cyc = cyc; end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        incs = 0; decs = 0; done_n = 0; first_psen = -1; overlap = 0;
        m_hit = 0; m_trig = 0; pos = 0; ps_cd = 0;
        recs.delete();
    endtask

    task automatic do_start();
        u.start = 1;
        tick();
        u.start = 0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = u.done === 1'b1;
        end
    endtask

    function automatic void model_edge(output bit f, output int s);
        f = 0;
        s = 0;
        for (int i = 1; i < recs.size(); i++)
            if (!f && recs[i].exp >= HALF && recs[i-1].exp < HALF) begin f = 1; s = i; end
    endfunction

    task automatic test_reset();
        rst = 1;
        tick();
        tick();
        checks++; if ({u.busy, u.done, u.timeout_err, u.psen, u.psincdec, u.trigger_out, u.res_valid, u.edge_found} !== 8'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0", {u.busy, u.done, u.timeout_err, u.psen, u.psincdec, u.trigger_out, u.res_valid, u.edge_found}); end
        checks++; if ({u.res_step, u.res_count, u.edge_step} !== 12'b0) begin errors++; $display("FAIL reset_values: got %h expected 0", {u.res_step, u.res_count, u.edge_step}); end
        rst = 0;
        tick();
    endtask

    task automatic test_nominal();
        bit ok;
        clear_model();
        mode = 3;
        ps_delay = 3;
        do_start();
        checks++; if (u.busy !== 1'b1) begin errors++; $display("FAIL nom_busy: got %b expected 1", u.busy); end
        wait_done(2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL nom_done: got 0 expected 1"); end
        checks++; if (u.busy !== 1'b0) begin errors++; $display("FAIL nom_busy_at_done: got %b expected 0", u.busy); end
        tick();
        checks++; if (u.done !== 1'b0) begin errors++; $display("FAIL nom_done_pulse: got %b expected 0", u.done); end
        checks++; if (recs.size() != STEPS) begin errors++; $display("FAIL nom_results: got %0d expected %0d", recs.size(), STEPS); end
        for (int i = 0; i < recs.size(); i++) begin
            checks++; if (recs[i].cnt != (i >= 2 ? AVER : 0) || recs[i].cnt != recs[i].exp) begin errors++; $display("FAIL nom_count%0d: got %0d expected %0d", i, recs[i].cnt, recs[i].exp); end
            checks++; if (recs[i].step != i) begin errors++; $display("FAIL nom_step%0d: got %0d expected %0d", i, recs[i].step, i); end
        end
        checks++; if (u.edge_found !== 1'b1 || u.edge_step !== 3'd2) begin errors++; $display("FAIL nom_edge: got %b/%0d expected 1/2", u.edge_found, u.edge_step); end
        checks++; if (incs != 3 || decs != 3) begin errors++; $display("FAIL nom_shifts: got %0d/%0d expected 3/3", incs, decs); end
        checks++; if (done_n != 1 || u.timeout_err !== 1'b0) begin errors++; $display("FAIL nom_finish: got done %0d err %b expected 1/0", done_n, u.timeout_err); end
        checks++; if (pos != 0 || overlap != 0) begin errors++; $display("FAIL nom_phase: got pos %0d overlap %0d expected 0/0", pos, overlap); end
    endtask

    task automatic test_trigger_timing();
        bit ok;
        for (int m = 1; m <= 2; m++) begin
            clear_model();
            mode = m;
            do_start();
            wait_done(2000, ok);
            tick();
            checks++; if (!ok || recs.size() != STEPS) begin errors++; $display("FAIL trig_results_m%0d: got %0d expected %0d", m, recs.size(), STEPS); end
            foreach (recs[i]) begin
                checks++; if (recs[i].cnt != (m == 1 ? AVER : 0) || recs[i].cnt != recs[i].exp) begin errors++; $display("FAIL trig_count_m%0d_%0d: got %0d expected %0d", m, i, recs[i].cnt, m == 1 ? AVER : 0); end
                checks++; if (recs[i].trigs != AVER) begin errors++; $display("FAIL trig_pulses_m%0d_%0d: got %0d expected %0d", m, i, recs[i].trigs, AVER); end
            end
            checks++; if (u.edge_found !== 1'b0) begin errors++; $display("FAIL trig_edge_m%0d: got %b expected 0", m, u.edge_found); end
        end
    endtask

    task automatic test_random();
        bit ok, ef;
        int es, base;
        for (int r = 0; r < 3; r++) begin
            clear_model();
            mode = 0;
            ps_delay = $urandom_range(1, 6);
            base = $urandom_range(0, 30);
            for (int k = 0; k < 8; k++) prob[k] = base + k * int'($urandom_range(5, 40));
            do_start();
            wait_done(3000, ok);
            tick();
            checks++; if (!ok || recs.size() != STEPS) begin errors++; $display("FAIL rnd%0d_results: got %0d expected %0d", r, recs.size(), STEPS); end
            foreach (recs[i]) begin
                checks++; if (recs[i].cnt != recs[i].exp || recs[i].step != i) begin errors++; $display("FAIL rnd%0d_count%0d: got %0d@%0d expected %0d@%0d", r, i, recs[i].cnt, recs[i].step, recs[i].exp, i); end
            end
            model_edge(ef, es);
            checks++; if (u.edge_found !== ef || (ef && int'(u.edge_step) != es)) begin errors++; $display("FAIL rnd%0d_edge: got %b/%0d expected %b/%0d", r, u.edge_found, u.edge_step, ef, es); end
            checks++; if (incs != 3 || decs != 3 || pos != 0) begin errors++; $display("FAIL rnd%0d_shifts: got %0d/%0d pos %0d expected 3/3 pos 0", r, incs, decs, pos); end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        clear_model();
        mode = 3;
        ps_delay = 0;
        do_start();
        wait_done(500, ok);
        checks++; if (!ok || u.timeout_err !== 1'b1) begin errors++; $display("FAIL to_err: got done %b err %b expected 1/1", ok, u.timeout_err); end
        tick();
        checks++; if (done_cyc - first_psen != 21) begin errors++; $display("FAIL to_latency: got %0d expected 21", done_cyc - first_psen); end
        checks++; if (incs != 1 || decs != 0 || done_n != 1) begin errors++; $display("FAIL to_shifts: got %0d/%0d done %0d expected 1/0 done 1", incs, decs, done_n); end
        checks++; if (u.timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", u.timeout_err); end
        clear_model();
        ps_delay = 3;
        do_start();
        checks++; if (u.timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b expected 0", u.timeout_err); end
        wait_done(2000, ok);
        tick();
        checks++; if (!ok || u.timeout_err !== 1'b0 || recs.size() != STEPS) begin errors++; $display("FAIL to_rerun: got done %b err %b results %0d expected 1/0/%0d", ok, u.timeout_err, recs.size(), STEPS); end
    endtask

    task automatic test_abort_meas();
        bit ok;
        int i;
        clear_model();
        mode = 3;
        for (i = 0; i < 2000 && recs.size() < 2; i++) tick();
        if (i == 0) ;
        do_start();
        for (i = 0; i < 2000 && recs.size() < 2; i++) tick();
        for (i = 0; i < 100 && u.trigger_out !== 1'b1; i++) tick();
        checks++; if (u.trigger_out !== 1'b1) begin errors++; $display("FAIL abm_reach: got %b expected 1", u.trigger_out); end
        u.abort = 1;
        tick();
        u.abort = 0;
        wait_done(500, ok);
        checks++; if (!ok || u.busy !== 1'b0) begin errors++; $display("FAIL abm_done: got done %b busy %b expected 1/0", ok, u.busy); end
        tick();
        checks++; if (recs.size() != 2) begin errors++; $display("FAIL abm_results: got %0d expected 2", recs.size()); end
        checks++; if (incs != 2 || decs != 2 || pos != 0) begin errors++; $display("FAIL abm_shifts: got %0d/%0d pos %0d expected 2/2 pos 0", incs, decs, pos); end
        checks++; if (done_n != 1 || u.timeout_err !== 1'b0) begin errors++; $display("FAIL abm_finish: got %0d err %b expected 1/0", done_n, u.timeout_err); end
    endtask

    task automatic test_abort_wait_ps();
        bit ok;
        clear_model();
        mode = 3;
        ps_delay = 5;
        do_start();
        for (int i = 0; i < 2000 && !(u.psen === 1'b1 && recs.size() == 2); i++) tick();
        checks++; if (u.psen !== 1'b1 || u.psincdec !== 1'b1) begin errors++; $display("FAIL abw_reach: got %b/%b expected 1/1", u.psen, u.psincdec); end
        tick();
        u.abort = 1;
        tick();
        u.abort = 0;
        wait_done(500, ok);
        tick();
        checks++; if (!ok || done_n != 1) begin errors++; $display("FAIL abw_done: got %0d expected 1", done_n); end
        checks++; if (incs != 2 || decs != 2 || pos != 0) begin errors++; $display("FAIL abw_shifts: got %0d/%0d pos %0d expected 2/2 pos 0", incs, decs, pos); end
        checks++; if (overlap != 0 || recs.size() != 2) begin errors++; $display("FAIL abw_order: got overlap %0d results %0d expected 0/2", overlap, recs.size()); end
        ps_delay = 3;
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_model();
        mode = 1;
        do_start();
        for (int i = 0; i < 200 && u.trigger_out !== 1'b1; i++) tick();
        rst = 1;
        #1;
        checks++; if ({u.busy, u.done, u.psen, u.trigger_out, u.res_valid, u.edge_found, u.res_count} !== 12'b0) begin errors++; $display("FAIL rstmid_outputs: got %h expected 0", {u.busy, u.done, u.psen, u.trigger_out, u.res_valid, u.edge_found, u.res_count}); end
        tick();
        rst = 0;
        tick();
        clear_model();
        mode = 3;
        do_start();
        repeat (30) tick();
        do_start();
        checks++; if (u.busy !== 1'b1) begin errors++; $display("FAIL busy_start_busy: got %b expected 1", u.busy); end
        wait_done(2000, ok);
        tick();
        checks++; if (!ok || done_n != 1 || recs.size() != STEPS) begin errors++; $display("FAIL busy_start_once: got done %0d results %0d expected 1/%0d", done_n, recs.size(), STEPS); end
        foreach (recs[i]) begin
            checks++; if (recs[i].step != i) begin errors++; $display("FAIL busy_start_step%0d: got %0d expected %0d", i, recs[i].step, i); end
        end
    endtask

    task automatic test_small_counter();
        int n = 0;
        bit ok = 0;
        u2.start = 1;
        tick();
        u2.start = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            tick();
            if (u2.res_valid === 1'b1) begin
                checks++; if (u2.res_count !== 3'd7 || int'(u2.res_step) != n) begin errors++; $display("FAIL small_count%0d: got %0d@%0d expected 7@%0d", n, u2.res_count, u2.res_step, n); end
                n++;
            end
            ok = u2.done === 1'b1;
        end
        checks++; if (!ok || n != 2 || u2.edge_found !== 1'b0) begin errors++; $display("FAIL small_sweep: got done %b results %0d edge %b expected 1/2/0", ok, n, u2.edge_found); end
    endtask

    initial begin
        rst = 1;
        u.start = 0;
        u.abort = 0;
        u2.start = 0;
        u2.abort = 0;
        u2.psdone = 1;
        u2.probe_sync = 1;
        test_reset();
        test_nominal();
        test_trigger_timing();
        test_random();
        test_timeout();
        test_abort_meas();
        test_abort_wait_ps();
        test_reset_mid();
        test_small_counter();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/probe_phase_sweeper.md
Name: probe_phase_sweeper

Overview:
Sequencer that sweeps the sampling phase of shifting_clk through an MMCM dynamic phase-shift port and runs one probe measurement per phase step. At each step it issues AVER_TIME trigger pulses and counts how many sampled probe hits follow each trigger. It streams one result per step, locates the first low-to-high crossing of the half-count threshold, and returns the MMCM to its starting phase. It sits in the shifting_clk domain, between the AXI register front end (start/abort/results) and the MMCM PS port.

Parameters:
NUM_STEPS, 56, number of phase steps measured (step 0 is the unshifted phase)
STEP_W, 10, width of step indices; must satisfy 2^STEP_W > NUM_STEPS
COUNT_W, 14, width of hit counter
AVER_TIME, 10000, triggers per step; must be < 2^COUNT_W
SETTLE_CYC, 16, idle cycles after a phase change before measuring (minimum 1)
PS_TIMEOUT, 1023, maximum cycles to wait for psdone

Ports:
shifting_clk  in  1  clock
shifting_rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle sweep request
abort  in  1  one-cycle abort request
busy  out  1  high from the cycle after an accepted start until the done pulse
done  out  1  one-cycle pulse at the end of a sweep, an abort or an error
timeout_err  out  1  sticky; cleared by an accepted start
psen  out  1  MMCM phase-shift enable, one-cycle pulse
psincdec  out  1  1 = increment, 0 = decrement; valid while psen is high
psdone  in  1  MMCM phase-shift complete
trigger_out  out  1  launches a probe transition
probe_sync  in  1  probe sample, already synchronised to shifting_clk
res_valid  out  1  one-cycle pulse per completed step
res_step  out  STEP_W  step index of the result
res_count  out  COUNT_W  hits for that step
edge_found  out  1  a threshold crossing was seen; held until the next start
edge_step  out  STEP_W  first step with count >= AVER_TIME>>1 whose predecessor was below it

Behaviour:
- Reset: all outputs are 0. State is IDLE; step, trigger, hit and timeout counters are cleared.
- IDLE: start moves to SETTLE with step=0. Accepting start clears timeout_err, edge_found and edge_step. abort is ignored in IDLE; if start and abort arrive in the same IDLE cycle, start proceeds. start is ignored while busy.
- SETTLE: waits SETTLE_CYC cycles, then moves to MEAS.
- MEAS, a 5-cycle trigger slot repeated AVER_TIME times:
  - cycle T: trigger_out=1.
  - cycles N1, N2: idle.
  - cycle S: hits += probe_sync.
  - cycle G: idle.
  - hits saturate at 2^COUNT_W-1.
  - After the last slot, go to RECORD.
- RECORD, one cycle:
  - res_valid=1 with res_step=step and res_count=hits.
  - If step>0, hits >= AVER_TIME>>1, the previous count < AVER_TIME>>1 and edge_found is 0: set edge_found and edge_step=step.
  - Clear hits.
  - If step==NUM_STEPS-1, go to UNWIND; otherwise go to SHIFT.
- SHIFT: psen=1, psincdec=1 for one cycle, then WAIT_PS.
- WAIT_PS:
  - On psdone: step++ and go to SETTLE.
  - If PS_TIMEOUT cycles elapse with no psdone: go to ERR.
- UNWIND: issues one decrement per increment performed (count = step), one at a time. Each decrement is a psen pulse with psincdec=0, then a wait for psdone under the same timeout. When the remaining count reaches 0, go to FINISH.
- FINISH: done=1 for one cycle, busy=0, return to IDLE. Total sweep latency is deterministic for a fixed psdone delay.
- ERR: timeout_err=1, done pulse, return to IDLE without unwinding. The phase is left unknown; software must reset the MMCM.
- Abort during SETTLE or MEAS: the partial step is discarded (no res_valid), hits are cleared and the FSM goes to UNWIND with count = step.
- Abort during WAIT_PS: latched; the FSM waits for psdone (no psen may be issued while a shift is pending), performs step++, then unwinds.
- Abort during UNWIND or RECORD: RECORD completes normally, then the latched abort is honoured (go to UNWIND). During UNWIND, abort has no further effect.
- psdone outside WAIT_PS or the unwind wait is ignored.
- Asserting reset mid-sweep returns everything to reset values immediately. No unwind is performed.

Test Plan:
- Nominal sweep: NUM_STEPS=4, AVER_TIME=8, SETTLE_CYC=2, psdone 3 cycles after psen, probe_sync=1 only during steps 2-3 -> res_count 0,0,8,8; edge_found=1, edge_step=2; 3 increments then 3 decrements; one done pulse; timeout_err=0.
- Trigger timing: probe_sync=1 only in the cycle exactly 3 after each trigger_out -> res_count=8 every step; the same probe shifted by 1 cycle -> res_count=0.
- Timeout: psdone never asserted, PS_TIMEOUT=20 -> 21 cycles after the first psen, timeout_err=1 and done pulse, no decrements issued; the next start clears timeout_err.
- Abort in MEAS at step 2 -> no res_valid for step 2; exactly 2 decrement pulses; done pulse; busy=0.
- Abort during WAIT_PS (step 1→2 shift) -> waits for psdone, then exactly 2 decrements.
- Reset mid-MEAS -> all outputs 0 next cycle; start ignored while busy; with COUNT_W=3 and AVER_TIME=7, all-ones probe gives res_count=7.
